// File: rtl/mcc_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM:
// state codes, opcodes and datapath mux selects.
package mcc_pkg;

    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD  = 4'd4,
        S_MEM_WB  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_EXEC    = 4'd7,
        S_ALU_WB  = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_ADDI_EX = 4'd11,
        S_ADDI_WB = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // States that wait on the memory handshake (FETCH only when running).
    function automatic logic is_mem_wait(state_t s, logic run);
        return ((s == S_FETCH) && run) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mcc_mem_timer.sv
// Memory-wait watchdog: counts stalled cycles, flags when the limit is hit.
module mcc_mem_timer #(
    parameter int TIMEOUT_W   = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TIMEOUT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == TIMEOUT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_mips_control.sv
// Multi-cycle MIPS control FSM with memory-ready watchdog.
// Optional perf counters enabled by MCC_PERF_CNT_EN.
module multicycle_mips_control
    import mcc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TIMEOUT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        ir_write,
    output logic [1:0]  pc_source,
    output logic [1:0]  alu_op,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        instr_done,
    output logic        illegal_op,
    output logic        mem_timeout,
    output logic [3:0]  state,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);

    state_t cur_state;
    state_t next_state;
    logic   mem_wait;
    logic   expired;
    logic   tmo;
    logic   timer_clr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= S_RST;
        end else begin
            cur_state <= next_state;
        end
    end

    assign mem_wait  = is_mem_wait(cur_state, run);
    assign tmo       = mem_wait && !mem_ready && expired;
    // Restart the count on every state entry and after an abort.
    assign timer_clr = (next_state != cur_state) || !mem_wait || tmo;

    mcc_mem_timer #(
        .TIMEOUT_W   (TIMEOUT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (timer_clr),
        .en      (mem_wait && !mem_ready),
        .expired (expired)
    );

    always_comb begin
        next_state    = cur_state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        pc_source     = PC_SRC_ALU;
        alu_op        = ALU_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_REG;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        mem_timeout   = tmo;

        unique case (cur_state)
            S_RST: begin
                next_state = S_FETCH;
            end
            S_FETCH: begin
                alu_src_b = SRC_B_FOUR;
                mem_read  = run && !tmo;
                ir_write  = run && mem_ready;
                pc_write  = run && mem_ready;
                if (run && mem_ready) begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = SRC_B_IMM_SH;
                unique case (1'b1)
                    (opcode == OP_RTYPE): next_state = S_EXEC;
                    (opcode == OP_LW),
                    (opcode == OP_SW):    next_state = S_MEM_ADDR;
                    (opcode == OP_BEQ):   next_state = S_BRANCH;
                    (opcode == OP_J):     next_state = S_JUMP;
                    (opcode == OP_ADDI):  next_state = S_ADDI_EX;
                    default: begin
                        illegal_op = 1'b1;
                        next_state = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_IMM;
                next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = !tmo;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    next_state = S_MEM_WB;
                end else if (tmo) begin
                    next_state = S_FETCH;
                end
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write  = !tmo;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
                if (mem_ready || tmo) begin
                    next_state = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_FUNCT;
                next_state = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_SRC_ALUOUT;
                instr_done    = 1'b1;
                next_state    = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PC_SRC_JUMP;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_IMM;
                next_state = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            default: begin
                next_state = S_RST;
            end
        endcase
    end

    assign state = cur_state;

`ifdef MCC_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (instr_done) begin
                instr_count <= instr_count + 32'd1;
            end
        end
    end
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif

endmodule

// File: doc/multicycle_mips_control.md
Name: multicycle_mips_control

Overview:
Control FSM that sequences a multi-cycle MIPS datapath: shared instruction/data memory, IR, A/B/ALUOut registers, one ALU. Decodes opcode from the IR and drives Moore-style per-state control signals. Waits on a memory-ready handshake, with a timeout watchdog. Replaces the single-cycle Control unit; the existing ALUcontrol block is reused downstream of alu_op.

Parameters:
MEM_TIMEOUT, 15, max cycles a memory state waits for mem_ready before aborting (1..2^TIMEOUT_W-1)
TIMEOUT_W, 4, width of the timeout counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
run  in  1  1 = fetch new instructions; 0 = park in FETCH
opcode  in  6  IR[31:26]
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (beq)
i_or_d  out  1  memory address: 0=PC, 1=ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_to_reg  out  1  register write data: 0=ALUOut, 1=MDR
ir_write  out  1  load IR
pc_source  out  2  00=ALU, 01=ALUOut, 10=jump target
alu_op  out  2  00=add, 01=sub, 10=funct
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
reg_write  out  1  register file write enable
reg_dst  out  1  0=rt, 1=rd
instr_done  out  1  one-cycle pulse on the final cycle of each instruction
illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode
mem_timeout  out  1  one-cycle pulse when a memory access aborts
state  out  4  current state, debug
cycle_count  out  32  perf counter (see Optional Feature)
instr_count  out  32  perf counter (see Optional Feature)

Behaviour:
- States and encodings: RST=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, EXEC=7, ALU_WB=8, BRANCH=9, JUMP=10, ADDI_EX=11, ADDI_WB=12.
- Reset (reset=0): state=RST; every output is 0; counters are 0. After release, RST goes to FETCH on the next edge.
- Outputs not listed for a state are 0.
- FETCH:
  - mem_read=run, alu_src_b=01.
  - ir_write and pc_write = run & mem_ready.
  - run=0: stay in FETCH.
  - run=1 & mem_ready=1: go to DECODE.
- DECODE:
  - alu_src_b=11.
  - Next state by opcode: 000000 to EXEC; 100011/101011 to MEM_ADDR; 000100 to BRANCH; 000010 to JUMP; 001000 to ADDI_EX.
  - Any other opcode: illegal_op=1, go to FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10. Go to MEM_RD if opcode=100011, else MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Go to MEM_WB on mem_ready.
- MEM_WB: mem_to_reg=1, reg_write=1, instr_done=1. Go to FETCH.
- MEM_WR: mem_write=1, i_or_d=1, instr_done=mem_ready. Go to FETCH on mem_ready.
- EXEC: alu_src_a=1, alu_op=10. Go to ALU_WB.
- ALU_WB: reg_dst=1, reg_write=1, instr_done=1. Go to FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Go to FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Go to FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10. Go to ADDI_WB.
- ADDI_WB: reg_write=1, instr_done=1. Go to FETCH.
- Latency in cycles, zero wait states: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
- Timeout watchdog:
  - Counter clears on entry to FETCH (with run=1), MEM_RD or MEM_WR. It increments each cycle mem_ready=0 in those states.
  - When the counter equals MEM_TIMEOUT with mem_ready=0: mem_timeout=1, strobes forced 0 that cycle, go to FETCH.
  - mem_ready=1 in that same cycle wins; no timeout.
- opcode is sampled only in DECODE and MEM_ADDR; the IR holds it stable.
- reset asserted mid-instruction: immediate return to RST; no partial write completes.

Optional Feature:
MCC_PERF_CNT_EN:
- Defined:
  - cycle_count increments every cycle out of reset.
  - instr_count increments on instr_done.
  - Both wrap at 2^32 and clear on reset.
- Undefined: both ports are constant 0; no counter flops.

Decomposition:
- Package mcc_pkg: state encodings, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), alu_op / alu_src_b / pc_source encodings.
- Sub-module mcc_mem_timer: TIMEOUT_W-bit counter with clear/enable inputs and an expired output.

Test Plan:
1. Reset held low for 3 cycles, then released, run=1, opcode=000000, mem_ready=1 -> state sequence 0,1,2,7,8,1; reg_dst=1 and reg_write=1 in ALU_WB; instr_done pulses once.
2. lw (100011) with mem_ready low for 2 cycles in MEM_RD -> MEM_RD held 3 cycles with mem_read=1, i_or_d=1; MEM_WB has mem_to_reg=1; total 7 cycles.
3. sw (101011) with mem_ready never high, MEM_TIMEOUT=15 -> mem_timeout pulses 16 cycles after MEM_WR entry; mem_write=0 on that cycle; next state FETCH.
4. beq (000100), then j (000010) -> 3 cycles each; pc_write_cond=1/pc_source=01, then pc_write=1/pc_source=10; no reg_write.
5. Opcode 111111 -> illegal_op=1 in DECODE; next state FETCH; no instr_done.
6. reset driven low while in MEM_WR with mem_ready=0 -> all outputs 0 asynchronously; with MCC_PERF_CNT_EN, instr_count=0 afterwards and equals 5 after 5 R-types.
